// File: rtl/arm_mem_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
package arm_mem_pkg;

  // Data access size as presented on DSIZE
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } dsize_t;

  // Which port owns the SRAM response arriving in the following cycle
  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_I,
    OWN_D_RD,
    OWN_D_WR,
    OWN_D_ERR
  } owner_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mem_lane_decode.sv
// Data-port lane decode: byte enables, write-lane replication, misalign flag.
import arm_mem_pkg::*;

module mem_lane_decode (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offs,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  // Map size/offset to lane enables and replicate narrow write data to all lanes
  always_comb begin
    o_be       = BE_NONE;
    o_wdata    = '0;
    o_misalign = 1'b0;
    case (dsize_t'(i_size))
      SZ_BYTE: begin
        o_be    = BE_BYTE0 << i_offs;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_wdata = {2{i_wdata[15:0]}};
        if (i_offs == 2'b00)      o_be = BE_HALF_LO;
        else if (i_offs == 2'b10) o_be = BE_HALF_HI;
        else                      o_misalign = 1'b1;
      end
      SZ_WORD: begin
        o_wdata = i_wdata;
        if (i_offs == 2'b00) o_be = BE_WORD;
        else                 o_misalign = 1'b1;
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port SRAM shared by the fetch and data ports: data priority with a
// starvation guard for fetch, one access per cycle, 1-cycle response routing.
import arm_mem_pkg::*;

module unified_mem_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IREQ,
  input  logic [31:0]       IADDR,
  output logic              IGNT,
  output logic              IRVALID,
  output logic [31:0]       INSTR,
  input  logic              DREQ,
  input  logic [31:0]       DADDR,
  input  logic              DRW,
  input  logic [1:0]        DSIZE,
  input  logic [31:0]       DOUT,
  output logic              DGNT,
  output logic              DRVALID,
  output logic              DERR,
  output logic [31:0]       DIN,
  output logic              MEM_CSN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DO
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_starve;
  owner_t           r_owner;

  logic        w_force_i;
  logic        w_dgnt;
  logic        w_ignt;
  logic        w_d_access;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misalign;
  logic        w_unused;

  // Address bits outside the SRAM word range are intentionally ignored
  assign w_unused = ^{IADDR[31:ADDR_W+2], IADDR[1:0], DADDR[31:ADDR_W+2]};

  mem_lane_decode u_lane (
    .i_size     (DSIZE),
    .i_offs     (DADDR[1:0]),
    .i_wdata    (DOUT),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign)
  );

  // Arbitration: data wins unless fetch has waited out STARVE_MAX data grants.
  // Grants are qualified by RESET_N so they read zero while reset is held.
  always_comb begin
    w_force_i  = IREQ && (r_starve == STARVE_LIM);
    w_dgnt     = RESET_N && DREQ && !w_force_i;
    w_ignt     = RESET_N && IREQ && !w_dgnt;
    w_d_access = w_dgnt && !w_misalign;
    IGNT       = w_ignt;
    DGNT       = w_dgnt;
  end

  // SRAM address/control mux for the access granted this cycle
  always_comb begin
    MEM_CSN  = 1'b1;
    MEM_WE   = 1'b0;
    MEM_BE   = BE_NONE;
    MEM_ADDR = '0;
    MEM_DI   = '0;
    if (w_d_access) begin
      MEM_CSN  = 1'b0;
      MEM_ADDR = DADDR[ADDR_W+1:2];
      MEM_WE   = DRW;
      MEM_BE   = w_be;
      MEM_DI   = DRW ? w_wdata : '0;
    end else if (w_ignt) begin
      MEM_CSN  = 1'b0;
      MEM_ADDR = IADDR[ADDR_W+1:2];
      MEM_BE   = BE_WORD;
    end
  end

  // Starvation counter: counts data grants that bypassed a waiting fetch
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_starve <= '0;
    end else if (!IREQ || w_ignt) begin
      r_starve <= '0;
    end else if (w_dgnt && (r_starve != STARVE_LIM)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Owner register: remembers who gets the response in the next cycle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_owner <= OWN_NONE;
    end else if (w_dgnt) begin
      if (w_misalign) r_owner <= OWN_D_ERR;
      else if (DRW)   r_owner <= OWN_D_WR;
      else            r_owner <= OWN_D_RD;
    end else if (w_ignt) begin
      r_owner <= OWN_I;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  // Response steering of the SRAM read data to the owning port
  always_comb begin
    IRVALID = (r_owner == OWN_I);
    INSTR   = (r_owner == OWN_I) ? MEM_DO : '0;
    DRVALID = (r_owner == OWN_D_RD) || (r_owner == OWN_D_WR) || (r_owner == OWN_D_ERR);
    DERR    = (r_owner == OWN_D_ERR);
    DIN     = (r_owner == OWN_D_RD) ? MEM_DO : '0;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter with a transaction-level reference
// model (priority rules, byte-lane memory image, pending-response tracking).
module tb_unified_mem_arbiter;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned WORDS      = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              IREQ;
  logic [31:0]       IADDR;
  logic              IGNT, IRVALID;
  logic [31:0]       INSTR;
  logic              DREQ;
  logic [31:0]       DADDR;
  logic              DRW;
  logic [1:0]        DSIZE;
  logic [31:0]       DOUT;
  logic              DGNT, DRVALID, DERR;
  logic [31:0]       DIN;
  logic              MEM_CSN, MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [3:0]        MEM_BE;
  logic [31:0]       MEM_DI;
  logic [31:0]       MEM_DO;

  int n_checks = 0;
  int n_err    = 0;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT), .IRVALID(IRVALID), .INSTR(INSTR),
    .DREQ(DREQ), .DADDR(DADDR), .DRW(DRW), .DSIZE(DSIZE), .DOUT(DOUT),
    .DGNT(DGNT), .DRVALID(DRVALID), .DERR(DERR), .DIN(DIN),
    .MEM_CSN(MEM_CSN), .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE),
    .MEM_DI(MEM_DI), .MEM_DO(MEM_DO)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 4) return 32'hE7FE_46C0;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Behavioural synchronous SRAM driven by the DUT
  logic [31:0] sram [WORDS];
  logic        mem_init = 1'b1;
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < WORDS; i++) sram[i] <= init_word(i);
    end else if (!MEM_CSN) begin
      if (MEM_WE) begin
        for (int b = 0; b < 4; b++)
          if (MEM_BE[b]) sram[MEM_ADDR][8*b +: 8] <= MEM_DI[8*b +: 8];
      end else begin
        MEM_DO <= sram[MEM_ADDR];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [WORDS];
  int          starve    = 0;
  int          pend_kind = 0;   // 0 none, 1 fetch, 2 data read, 3 data write, 4 data error
  logic [31:0] pend_data = '0;
  bit          last_ig   = 0;
  bit          last_dg   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Let inputs settle, compare every output against the model, advance the model
  task automatic settle();
    bit          force_i, egi, egd, mis, chk_di;
    int          n, offs;
    logic [3:0]  ebe, e_be;
    logic [31:0] edi, e_di;
    logic        e_csn, e_we;
    logic [ADDR_W-1:0] e_addr, wa;
    #1;
    if (!RESET_N) begin
      pend_kind = 0;
      starve    = 0;
    end
    chk("irvalid", IRVALID, 32'(pend_kind == 1));
    chk("instr",   INSTR,   (pend_kind == 1) ? pend_data : 32'h0);
    chk("drvalid", DRVALID, 32'(pend_kind >= 2));
    chk("derr",    DERR,    32'(pend_kind == 4));
    chk("din",     DIN,     (pend_kind == 2) ? pend_data : 32'h0);

    force_i = IREQ && (starve == STARVE_MAX);
    egd = RESET_N && DREQ && !force_i;
    egi = RESET_N && IREQ && !egd;

    offs = int'(DADDR[1:0]);
    n    = 1 << DSIZE;
    mis  = (DSIZE == 2'b11) || ((offs % n) != 0);
    ebe  = 4'(((1 << n) - 1) << offs);
    edi  = (n == 1) ? DOUT[7:0] * 32'h0101_0101 :
           (n == 2) ? DOUT[15:0] * 32'h0001_0001 : DOUT;
    wa   = DADDR[ADDR_W+1:2];

    e_csn = 1'b1; e_we = 1'b0; e_be = 4'h0; e_addr = '0; e_di = '0; chk_di = 1;
    if (egd && !mis) begin
      e_csn = 1'b0; e_addr = wa; e_we = DRW; e_be = ebe; e_di = edi; chk_di = DRW;
    end else if (egi) begin
      e_csn = 1'b0; e_addr = IADDR[ADDR_W+1:2]; e_be = 4'hF; chk_di = 0;
    end
    chk("ignt",     IGNT,     32'(egi));
    chk("dgnt",     DGNT,     32'(egd));
    chk("mem_csn",  MEM_CSN,  32'(e_csn));
    chk("mem_we",   MEM_WE,   32'(e_we));
    chk("mem_be",   MEM_BE,   32'(e_be));
    chk("mem_addr", MEM_ADDR, 32'(e_addr));
    if (chk_di) chk("mem_di", MEM_DI, e_di);

    pend_kind = 0;
    if (egi) begin
      pend_kind = 1;
      pend_data = ref_mem[IADDR[ADDR_W+1:2]];
    end
    if (egd) begin
      if (mis) pend_kind = 4;
      else if (DRW) begin
        for (int b = 0; b < 4; b++)
          if (ebe[b]) ref_mem[wa][8*b +: 8] = edi[8*b +: 8];
        pend_kind = 3;
      end else begin
        pend_kind = 2;
        pend_data = ref_mem[wa];
      end
    end
    if (!IREQ || egi)                        starve = 0;
    else if (egd && starve < STARVE_MAX)     starve++;
    last_ig = egi;
    last_dg = egd;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[ADDR_W+1:2] = 12'($urandom_range(63));
    return a;
  endfunction

  logic [31:0] t;

  initial begin
    for (int unsigned i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    RESET_N = 1'b0; IREQ = 0; IADDR = '0; DREQ = 0; DADDR = '0; DRW = 0; DSIZE = 0; DOUT = '0;
    @(negedge CLK); settle();
    @(negedge CLK); mem_init = 1'b0; settle();
    @(negedge CLK); RESET_N = 1'b1; settle();

    // Single fetch of word 4
    @(negedge CLK); IREQ = 1; IADDR = 32'h10; settle();
    chk("t1_ignt", IGNT, 1); chk("t1_addr", MEM_ADDR, 4);
    @(negedge CLK); IREQ = 0; settle();
    chk("t1_irvalid", IRVALID, 1); chk("t1_instr", INSTR, 32'hE7FE_46C0);

    // Byte write to 0x103 then word read of 0x100
    @(negedge CLK); DREQ = 1; DRW = 1; DSIZE = 2'b00; DADDR = 32'h103; DOUT = 32'hA5; settle();
    chk("t2_be", MEM_BE, 4'b1000); chk("t2_di", MEM_DI, 32'hA5A5_A5A5); chk("t2_we", MEM_WE, 1);
    @(negedge CLK); DRW = 0; DSIZE = 2'b10; DADDR = 32'h100; settle();
    @(negedge CLK); DREQ = 0; settle();
    t = DIN;
    chk("t2_din_hi", t[31:24], 32'hA5); chk("t2_drvalid", DRVALID, 1); chk("t2_derr", DERR, 0);

    // Both ports requesting continuously: D,D,D,D,I pattern
    @(negedge CLK); IREQ = 1; IADDR = rand_addr(); DREQ = 1; DRW = 0; DSIZE = 2'b10;
    DADDR = rand_addr() & 32'hFFFF_FFFC;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("t3_dgnt", DGNT, 32'((k % 5) != 4));
      chk("t3_ignt", IGNT, 32'((k % 5) == 4));
      @(negedge CLK);
      if (last_ig) IADDR = rand_addr();
      if (last_dg) DADDR = rand_addr() & 32'hFFFF_FFFC;
    end
    IREQ = 0; DREQ = 0; settle();

    // Misaligned half write: no SRAM access, error response, contents intact
    @(negedge CLK); DREQ = 1; DRW = 1; DSIZE = 2'b01; DADDR = 32'h101; DOUT = 32'h1234_BEEF; settle();
    chk("t4_dgnt", DGNT, 1); chk("t4_csn", MEM_CSN, 1);
    @(negedge CLK); DRW = 0; DSIZE = 2'b10; DADDR = 32'h100; settle();
    chk("t4_derr", DERR, 1); chk("t4_din", DIN, 0);
    @(negedge CLK); DREQ = 0; settle();

    // Reset right after a granted read discards its response
    @(negedge CLK); DREQ = 1; DRW = 0; DSIZE = 2'b10; DADDR = 32'h200; settle();
    chk("t5_dgnt", DGNT, 1);
    @(negedge CLK); RESET_N = 0; IREQ = 1; settle();
    chk("t5_rst_drvalid", DRVALID, 0); chk("t5_rst_dgnt", DGNT, 0); chk("t5_rst_csn", MEM_CSN, 1);
    @(negedge CLK); settle();
    @(negedge CLK); RESET_N = 1; IREQ = 0; DREQ = 0; settle();
    chk("t5_post_drvalid", DRVALID, 0);
    @(negedge CLK); settle();
    chk("t5_post2_drvalid", DRVALID, 0);

    // Illegal size with simultaneous fetch: only D granted, error response
    @(negedge CLK); DREQ = 1; DRW = 0; DSIZE = 2'b11; DADDR = 32'h40; IREQ = 1; IADDR = 32'h80; settle();
    chk("t6_dgnt", DGNT, 1); chk("t6_ignt", IGNT, 0);
    @(negedge CLK); DREQ = 0; settle();
    chk("t6_derr", DERR, 1); chk("t6_ignt2", IGNT, 1);
    @(negedge CLK); IREQ = 0; settle();

    // Randomized traffic; requesters hold until granted, may occasionally drop
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (!IREQ || last_ig || $urandom_range(9) == 0) begin
        IREQ  = ($urandom_range(9) < 6);
        IADDR = rand_addr();
      end
      if (!DREQ || last_dg || $urandom_range(9) == 0) begin
        DREQ  = ($urandom_range(9) < 6);
        DADDR = rand_addr();
        DRW   = 1'($urandom_range(1));
        DSIZE = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
        DOUT  = $urandom;
      end
      settle();
    end
    @(negedge CLK); IREQ = 0; DREQ = 0; settle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
